// File: rtl/roi_overlay_generator.sv
// Streaming ROI box overlay (filled/outline/blend) with config applied only at frame start; fixed 2-cycle latency, no backpressure.
// Optional centre crosshair inversion is compiled in when ROI_OVERLAY_CROSSHAIR_EN is defined.
module roi_overlay_generator #(
  parameter int          H_ACTIVE  = 800,
  parameter int          V_ACTIVE  = 600,
  parameter int          HALF_SIZE = 64,
  parameter int          BORDER_W  = 4,
  parameter logic [31:0] BOX_COLOR = 32'h000003ff
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [31:0] i_data,
  input  logic        i_cfg_valid,
  input  logic [1:0]  i_mode,
  input  logic [19:0] i_ul_addr,
  input  logic [19:0] i_ur_addr,
  input  logic [19:0] i_dl_addr,
  input  logic [19:0] i_dr_addr,
  output logic        o_valid,
  output logic        o_sof,
  output logic [31:0] o_data,
  output logic        o_cfg_pending
);
  localparam logic [11:0] HS    = 12'(HALF_SIZE);
  localparam logic [11:0] BW    = 12'(BORDER_W);
  localparam logic [11:0] HMAX  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] VMAX  = 12'(V_ACTIVE - 1);
  localparam logic [9:0]  HLAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  VLAST = 10'(V_ACTIVE - 1);

  logic [9:0]  row_cnt, col_cnt, cur_row, cur_col;
  logic        act_load;
  logic [11:0] row_sum, col_sum, cen_r, cen_c, hi_r, hi_c;
  logic [11:0] top_n, bot_n, lft_n, rgt_n;
  logic [1:0]  sh_mode, act_mode, eff_mode;
  logic [11:0] sh_top, sh_bot, sh_lft, sh_rgt;
  logic [11:0] act_top, act_bot, act_lft, act_rgt;
  logic [11:0] eff_top, eff_bot, eff_lft, eff_rgt, r12, c12;
  logic        in_box, on_edge;
  logic        s1_vld, s1_sof, s1_in, s1_edge;
  logic [1:0]  s1_mode;
  logic [31:0] s1_pix, blend, result;

  // i_sof overrides the counters so every frame resynchronises on its first beat
  assign cur_row  = i_sof ? 10'd0 : row_cnt;
  assign cur_col  = i_sof ? 10'd0 : col_cnt;
  assign act_load = i_valid && (cur_row == 10'd0) && (cur_col == 10'd0) && o_cfg_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (i_valid) begin
      if (cur_col == HLAST) begin
        col_cnt <= '0;
        row_cnt <= (cur_row == VLAST) ? 10'd0 : cur_row + 10'd1;
      end else begin
        col_cnt <= cur_col + 10'd1;
        row_cnt <= cur_row;
      end
    end
  end

  // Centre and clamped bounds are derived once, at shadow capture time
  always_comb begin
    row_sum = {2'b0, i_ul_addr[19:10]} + {2'b0, i_ur_addr[19:10]}
            + {2'b0, i_dl_addr[19:10]} + {2'b0, i_dr_addr[19:10]};
    col_sum = {2'b0, i_ul_addr[9:0]} + {2'b0, i_ur_addr[9:0]}
            + {2'b0, i_dl_addr[9:0]} + {2'b0, i_dr_addr[9:0]};
    cen_r   = row_sum >> 2;
    cen_c   = col_sum >> 2;
    hi_r    = cen_r + HS - 12'd1;
    hi_c    = cen_c + HS - 12'd1;
    top_n   = (cen_r >= HS) ? cen_r - HS : 12'd0;
    lft_n   = (cen_c >= HS) ? cen_c - HS : 12'd0;
    bot_n   = (hi_r > VMAX) ? VMAX : hi_r;
    rgt_n   = (hi_c > HMAX) ? HMAX : hi_c;
  end

`ifdef ROI_OVERLAY_CROSSHAIR_EN
  logic [9:0] sh_cr, sh_cc, act_cr, act_cc, eff_cr, eff_cc;
  logic       cross, s1_cross;
  assign eff_cr = act_load ? sh_cr : act_cr;
  assign eff_cc = act_load ? sh_cc : act_cc;
  assign cross  = (eff_mode != 2'b00) && in_box && (cur_row == eff_cr || cur_col == eff_cc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_cr    <= '0;
      sh_cc    <= '0;
      act_cr   <= '0;
      act_cc   <= '0;
      s1_cross <= 1'b0;
    end else begin
      if (i_cfg_valid) begin
        sh_cr <= cen_r[9:0];
        sh_cc <= cen_c[9:0];
      end
      if (act_load) begin
        act_cr <= sh_cr;
        act_cc <= sh_cc;
      end
      if (i_valid) s1_cross <= cross;
    end
  end
`endif

  // Nonblocking update lets a coincident capture and apply use the old shadow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_mode <= 2'b00; sh_top <= '0; sh_bot <= '0; sh_lft <= '0; sh_rgt <= '0;
      act_mode <= 2'b00; act_top <= '0; act_bot <= '0; act_lft <= '0; act_rgt <= '0;
      o_cfg_pending <= 1'b0;
    end else begin
      if (i_cfg_valid) begin
        sh_mode <= i_mode; sh_top <= top_n; sh_bot <= bot_n; sh_lft <= lft_n; sh_rgt <= rgt_n;
      end
      if (act_load) begin
        act_mode <= sh_mode; act_top <= sh_top; act_bot <= sh_bot; act_lft <= sh_lft; act_rgt <= sh_rgt;
      end
      if (i_cfg_valid)   o_cfg_pending <= 1'b1;
      else if (act_load) o_cfg_pending <= 1'b0;
    end
  end

  assign eff_mode = act_load ? sh_mode : act_mode;
  assign eff_top  = act_load ? sh_top  : act_top;
  assign eff_bot  = act_load ? sh_bot  : act_bot;
  assign eff_lft  = act_load ? sh_lft  : act_lft;
  assign eff_rgt  = act_load ? sh_rgt  : act_rgt;
  assign r12      = {2'b0, cur_row};
  assign c12      = {2'b0, cur_col};
  assign in_box   = (r12 >= eff_top) && (r12 <= eff_bot) && (c12 >= eff_lft) && (c12 <= eff_rgt);
  // Far-side tests add BW on the left so a thin box never underflows
  assign on_edge  = in_box && ((r12 < eff_top + BW) || (r12 + BW > eff_bot) ||
                               (c12 < eff_lft + BW) || (c12 + BW > eff_rgt));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0; s1_sof <= 1'b0; s1_pix <= '0; s1_in <= 1'b0; s1_edge <= 1'b0; s1_mode <= 2'b00;
    end else begin
      s1_vld <= i_valid;
      s1_sof <= i_valid & i_sof;
      if (i_valid) begin
        s1_pix <= i_data; s1_in <= in_box; s1_edge <= on_edge; s1_mode <= eff_mode;
      end
    end
  end

  always_comb begin
    blend  = {2'b00, (s1_pix[29:20] >> 1) + (BOX_COLOR[29:20] >> 1),
                     (s1_pix[19:10] >> 1) + (BOX_COLOR[19:10] >> 1),
                     (s1_pix[9:0]   >> 1) + (BOX_COLOR[9:0]   >> 1)};
    result = s1_pix;
    if (s1_in) begin
      case (s1_mode)
        2'b01:   result = BOX_COLOR;
        2'b10:   result = s1_edge ? BOX_COLOR : s1_pix;
        2'b11:   result = blend;
        default: result = s1_pix;
      endcase
    end
`ifdef ROI_OVERLAY_CROSSHAIR_EN
    if (s1_cross) result = {2'b00, ~s1_pix[29:0]};
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0; o_sof <= 1'b0; o_data <= '0;
    end else begin
      o_valid <= s1_vld;
      o_sof   <= s1_sof;
      if (s1_vld) o_data <= result;
    end
  end
endmodule
